// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, round constants, AES-128 round count and
// key/word types. Also holds the state encoding of the inverse key expander,
// whose FWD state exists only when AES_INVKEY_FWD_EXPAND_EN is defined.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    typedef logic [127:0] aes_key_t;
    typedef logic [31:0]  aes_word_t;

`ifdef AES_INVKEY_FWD_EXPAND_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_EMIT = 2'd2
    } inv_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd2
    } inv_state_t;
`endif

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index 0 is unused so that RCON[r] is the constant used by round r.
    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Out-of-range rounds yield zero rather than indexing past the table.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] r);
        logic [7:0] v;
        if ((r >= 4'd1) && (r <= NR)) begin
            v = RCON[r];
        end else begin
            v = 8'h00;
        end
        return v;
    endfunction

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel S-box lookups on one 32-bit word; purely combinational.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {sbox_lookup(word_in[31:24]), sbox_lookup(word_in[23:16]),
                       sbox_lookup(word_in[15:8]),  sbox_lookup(word_in[7:0])};

endmodule

// File: rtl/aes_inv_key_expansion.sv
// Reverse-order AES-128 round-key generator. Accepts the round-10 key and
// emits round keys 10 down to 0, one per OUT handshake, by undoing the key
// schedule one step per cycle with a single shared SubWord.
// Optional feature macro: AES_INVKEY_FWD_EXPAND_EN -- when defined, `key` is
// the cipher key and a FWD phase first runs the forward schedule to round 10.
module aes_inv_key_expansion
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         IN_valid,
    output logic         IN_ready,
    input  logic [127:0] key,
    output logic         OUT_valid,
    input  logic         OUT_ready,
    output logic [127:0] RoundKey,
    output logic [3:0]   round,
    output logic         last
);

    inv_state_t state_r;
    aes_key_t   key_r;
    logic [3:0] round_r;
    logic       out_valid_r;
    logic       last_r;

    aes_word_t  w0_s, w1_s, w2_s, w3_s;
    aes_word_t  t3_s;
    aes_word_t  sub_in_s;
    aes_word_t  sub_out_s;
    aes_key_t   inv_next_s;

    assign {w0_s, w1_s, w2_s, w3_s} = key_r;

    // Inverse step: recover the previous round's last three words by XOR,
    // then w0 needs SubWord(RotWord) of the recovered w3.
    assign t3_s       = w3_s ^ w2_s;
    assign inv_next_s = {w0_s ^ sub_out_s ^ {rcon_lookup(round_r), 24'h000000},
                         w1_s ^ w0_s, w2_s ^ w1_s, t3_s};

`ifdef AES_INVKEY_FWD_EXPAND_EN
    aes_word_t  f0_s, f1_s, f2_s;
    aes_key_t   fwd_next_s;

    assign f0_s       = w0_s ^ sub_out_s ^ {rcon_lookup(round_r + 4'd1), 24'h000000};
    assign f1_s       = w1_s ^ f0_s;
    assign f2_s       = w2_s ^ f1_s;
    assign fwd_next_s = {f0_s, f1_s, f2_s, w3_s ^ f2_s};

    // SubWord source: current w3 while expanding forward, recovered w3 otherwise.
    always_comb begin
        sub_in_s = rot_word(t3_s);
        if (state_r == ST_FWD) begin
            sub_in_s = rot_word(w3_s);
        end else begin
            sub_in_s = rot_word(t3_s);
        end
    end
`else
    assign sub_in_s = rot_word(t3_s);
`endif

    aes_sub_word u_sub_word (
        .word_in  (sub_in_s),
        .word_out (sub_out_s)
    );

    // Control FSM: accept a key, optionally expand forward, then walk rounds down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            key_r       <= 128'h0;
            round_r     <= 4'd0;
            out_valid_r <= 1'b0;
            last_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (IN_valid) begin
                        key_r  <= key;
                        last_r <= 1'b0;
`ifdef AES_INVKEY_FWD_EXPAND_EN
                        state_r     <= ST_FWD;
                        round_r     <= 4'd0;
                        out_valid_r <= 1'b0;
`else
                        state_r     <= ST_EMIT;
                        round_r     <= NR;
                        out_valid_r <= 1'b1;
`endif
                    end
                end
`ifdef AES_INVKEY_FWD_EXPAND_EN
                ST_FWD: begin
                    key_r   <= fwd_next_s;
                    round_r <= round_r + 4'd1;
                    if (round_r == (NR - 4'd1)) begin
                        state_r     <= ST_EMIT;
                        out_valid_r <= 1'b1;
                    end
                end
`endif
                ST_EMIT: begin
                    if (OUT_ready) begin
                        if (round_r == 4'd0) begin
                            state_r     <= ST_IDLE;
                            out_valid_r <= 1'b0;
                            last_r      <= 1'b0;
                        end else begin
                            key_r   <= inv_next_s;
                            round_r <= round_r - 4'd1;
                            last_r  <= (round_r == 4'd1);
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    last_r      <= 1'b0;
                end
            endcase
        end
    end

    assign IN_ready  = (state_r == ST_IDLE) && !reset;
    assign OUT_valid = out_valid_r;
    assign RoundKey  = key_r;
    assign round     = round_r;
    assign last      = last_r;

endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// Directed bench for aes_inv_key_expansion using the FIPS-197 AES-128 schedule.
module tb_aes_inv_key_expansion;

    logic         clk;
    logic         reset;
    logic         IN_valid;
    logic         IN_ready;
    logic [127:0] key;
    logic         OUT_valid;
    logic         OUT_ready;
    logic [127:0] RoundKey;
    logic [3:0]   round;
    logic         last;

    logic [127:0] exp_key [0:10];
    logic [127:0] in_key;
    int           tests;
    int           fails;

    aes_inv_key_expansion dut (
        .clk       (clk),
        .reset     (reset),
        .IN_valid  (IN_valid),
        .IN_ready  (IN_ready),
        .key       (key),
        .OUT_valid (OUT_valid),
        .OUT_ready (OUT_ready),
        .RoundKey  (RoundKey),
        .round     (round),
        .last      (last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_out(input int r);
        chk($sformatf("out_valid_r%0d", r), 128'(OUT_valid), 128'd1);
        chk($sformatf("round_r%0d", r), 128'(round), 128'(r));
        chk($sformatf("roundkey_r%0d", r), RoundKey, exp_key[r]);
        chk($sformatf("last_r%0d", r), 128'(last), 128'(r == 0));
    endtask

    task automatic start_key(input logic [127:0] k);
        chk("in_ready_before_accept", 128'(IN_ready), 128'd1);
        IN_valid = 1'b1;
        key      = k;
        tick();
        IN_valid = 1'b0;
        key      = 128'h0;
`ifdef AES_INVKEY_FWD_EXPAND_EN
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("fwd_quiet_%0d", i), 128'(OUT_valid), 128'd0);
            tick();
        end
`endif
    endtask

    initial begin
        exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef AES_INVKEY_FWD_EXPAND_EN
        in_key = exp_key[0];
`else
        in_key = exp_key[10];
`endif
        tests     = 0;
        fails     = 0;
        clk       = 1'b0;
        reset     = 1'b1;
        IN_valid  = 1'b0;
        key       = 128'h0;
        OUT_ready = 1'b1;

        // Reset state while reset is held.
        #2;
        chk("rst_in_ready", 128'(IN_ready), 128'd0);
        chk("rst_out_valid", 128'(OUT_valid), 128'd0);
        chk("rst_roundkey", RoundKey, 128'h0);
        chk("rst_round", 128'(round), 128'd0);
        chk("rst_last", 128'(last), 128'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 128'(IN_ready), 128'd1);

        // Full sequence with OUT_ready held high: 11 consecutive outputs.
        start_key(in_key);
        for (int r = 10; r >= 0; r--) begin
            check_out(r);
            tick();
        end
        chk("seq1_done_out_valid", 128'(OUT_valid), 128'd0);
        chk("seq1_done_in_ready", 128'(IN_ready), 128'd1);

        // Back-to-back key, with backpressure and a stray IN_valid at round 6.
        start_key(in_key);
        for (int r = 10; r >= 0; r--) begin
            check_out(r);
            if (r == 6) begin
                OUT_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    IN_valid = (i == 2);
                    key      = 128'hdeadbeef00112233445566778899aabb;
                    tick();
                    chk($sformatf("hold%0d_round", i), 128'(round), 128'd6);
                    chk($sformatf("hold%0d_key", i), RoundKey, exp_key[6]);
                    chk($sformatf("hold%0d_valid", i), 128'(OUT_valid), 128'd1);
                    chk($sformatf("hold%0d_in_ready", i), 128'(IN_ready), 128'd0);
                end
                IN_valid  = 1'b0;
                key       = 128'h0;
                OUT_ready = 1'b1;
            end
            tick();
        end
        chk("seq2_done_out_valid", 128'(OUT_valid), 128'd0);

        // Reset asserted while round 4 is presented.
        start_key(in_key);
        for (int r = 10; r >= 5; r--) begin
            check_out(r);
            tick();
        end
        check_out(4);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(OUT_valid), 128'd0);
        chk("midrst_roundkey", RoundKey, 128'h0);
        chk("midrst_round", 128'(round), 128'd0);
        chk("midrst_last", 128'(last), 128'd0);
        chk("midrst_in_ready", 128'(IN_ready), 128'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("after_midrst_in_ready", 128'(IN_ready), 128'd1);
        start_key(in_key);
        for (int r = 10; r >= 0; r--) begin
            check_out(r);
            tick();
        end
        chk("seq3_done_out_valid", 128'(OUT_valid), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
